// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the PCI physical-layer serial lane: the COM
// alignment/idle character, byte geometry and the receiver state encoding.
// The transmitter imports this package for COM as well.
package serial_paralelo_pkg;

    // Alignment and idle fill character.
    localparam logic [7:0] COM = 8'hBC;

    // Byte geometry of the serial lane.
    localparam int BITS_PER_BYTE = 8;
    localparam int BCNT_W        = $clog2(BITS_PER_BYTE);

    // Value of the bit counter on the cycle that samples the last bit of a byte.
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(BITS_PER_BYTE - 1);

    // Receiver alignment state.
    typedef enum logic [1:0] {
        UNALIGNED = 2'd0,
        ALIGNING  = 2'd1,
        ACTIVE    = 2'd2
    } rx_state_t;

    // True when a received byte is the given comma character.
    function automatic logic is_comma(input logic [7:0] rx_byte, input logic [7:0] comma);
        return rx_byte == comma;
    endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Lane-side bundle of the serial-to-parallel receiver: the serial bit in,
// the recovered byte with its qualifiers out. The receiver is the slave,
// the serial source / byte consumer side is the master.
interface serial_paralelo_rx_if;
    import serial_paralelo_pkg::*;

    logic                     data_in;
    logic [BITS_PER_BYTE-1:0] data_out;
    logic                     valid_out;
    logic                     byte_strb;
    logic                     active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strb,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strb,
        output active
    );

endinterface

// File: rtl/rx_shift_reg.sv
// Serial input shifter. Presents the byte that would be complete if the
// current bit were the last one of a byte, so the controller can test for
// COM on every cycle without waiting for the shift to settle.
module rx_shift_reg
    import serial_paralelo_pkg::*;
(
    input  logic                     clk_32f,
    input  logic                     reset,
    input  logic                     data_in,
    output logic [BITS_PER_BYTE-1:0] candidate
);

    logic [BITS_PER_BYTE-1:0] sr;

    // The oldest bit falls off the window before it is ever part of a
    // candidate, so it is carried only to keep the register byte-wide.
    logic unused_sr_msb;

    assign candidate     = {sr[BITS_PER_BYTE-2:0], data_in};
    assign unused_sr_msb = sr[BITS_PER_BYTE-1];

    // Shift one bit in per cycle, MSB of each byte arrives first.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr <= candidate;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver. Hunts for COM at any bit offset, confirms
// byte alignment on COMMA_COUNT consecutive aligned COMs, then delivers one
// byte every eight cycles, flagging non-COM bytes as valid data. Once
// active it stays active until reset.
module serial_paralelo_rx
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0] COMMA       = COM,
    parameter int         COMMA_COUNT = 4
)(
    input logic                  clk_32f,
    input logic                  reset,
    serial_paralelo_rx_if.slave  bus
);

    localparam logic [3:0] COMMA_TARGET = 4'(COMMA_COUNT);
    localparam bit         SINGLE_COM   = (COMMA_COUNT == 1);

    logic [BITS_PER_BYTE-1:0] candidate;
    logic                     cand_is_comma;
    logic                     boundary;

    rx_state_t                state;
    logic [BCNT_W-1:0]        bit_cnt;
    logic [3:0]               comma_cnt;
    logic [3:0]               comma_next;

    logic [BITS_PER_BYTE-1:0] data_q;
    logic                     valid_q;
    logic                     strb_q;
    logic                     active_q;

    rx_shift_reg u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (bus.data_in),
        .candidate (candidate)
    );

    assign cand_is_comma = is_comma(candidate, COMMA);
    assign boundary      = (bit_cnt == LAST_BIT);
    assign comma_next    = comma_cnt + 4'd1;

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.byte_strb = strb_q;
    assign bus.active    = active_q;

    // Alignment FSM with bit/COM counters and registered byte outputs.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state     <= UNALIGNED;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            strb_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            strb_q  <= 1'b0;
            // Free-running; wraps from the last bit back to zero. Realigned
            // when the first COM is found.
            bit_cnt <= bit_cnt + BCNT_W'(1);

            case (state)
                UNALIGNED: begin
                    // Any bit offset is acceptable here; the COM that matches
                    // defines where bytes start from now on.
                    if (cand_is_comma) begin
                        bit_cnt   <= '0;
                        comma_cnt <= 4'd1;
                        if (SINGLE_COM) begin
                            state    <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state <= ALIGNING;
                        end
                    end
                end

                ALIGNING: begin
                    if (boundary) begin
                        strb_q <= 1'b1;
                        if (cand_is_comma) begin
                            comma_cnt <= comma_next;
                            if (comma_next == COMMA_TARGET) begin
                                state    <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            // A non-COM at an aligned position means the
                            // first match was a false lock.
                            comma_cnt <= '0;
                            state     <= UNALIGNED;
                        end
                    end
                end

                ACTIVE: begin
                    if (boundary) begin
                        strb_q <= 1'b1;
                        if (cand_is_comma) begin
                            // Idle fill: keep the last data byte, drop valid.
                            valid_q <= 1'b0;
                        end else begin
                            data_q  <= candidate;
                            valid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= UNALIGNED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed lock/data/idle/false-lock/reset
// scenarios followed by randomized streams, all checked against a bit-stream
// reference model with a byte-strobe scoreboard.
module tb_serial_paralelo_rx;
    import serial_paralelo_pkg::*;

    localparam int CC = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    serial_paralelo_rx_if bus();

    serial_paralelo_rx #(.COMMA(COM), .COMMA_COUNT(CC)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    // Count of rising edges seen so far.
    int ecount = 0;
    always @(posedge clk_32f) ecount <= ecount + 1;

    typedef struct {
        int         edge_no;
        logic       valid;
        logic [7:0] data;
        logic       active;
    } strb_exp_t;

    strb_exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: the last eight bits on the wire, the position
    // inside the current byte once a COM fixed the framing (-1 if none),
    // the run of aligned COMs, and the expected output levels.
    logic [7:0] m_win    = 8'h00;
    int         m_phase  = -1;
    int         m_run    = 0;
    logic       m_locked = 1'b0;
    logic       m_valid  = 1'b0;
    logic [7:0] m_data   = 8'h00;

    logic rst_level     = 1'b0;
    int   last_bit_edge = 0;

    // Observations gathered by the monitor for directed checks.
    int strb_seen          = 0;
    int valid_cycles       = 0;
    int first_active_edge  = -1;
    int strb_before_active = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, ecount);
        end
    endtask

    task automatic model_reset();
        m_win    = 8'h00;
        m_phase  = -1;
        m_run    = 0;
        m_locked = 1'b0;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        exp_q.delete();
    endtask

    // Advance the model by one received bit; every byte boundary found in
    // the framed stream becomes an expected strobe on the scoreboard.
    task automatic model_bit(input logic b);
        strb_exp_t e;
        m_win = {m_win[6:0], b};
        if (m_phase < 0) begin
            if (m_win == COM) begin
                m_phase = 0;
                m_run   = 1;
                if (m_run == CC) m_locked = 1'b1;
            end
        end else begin
            m_phase++;
            if (m_phase == 8) begin
                m_phase = 0;
                if (!m_locked) begin
                    if (m_win == COM) begin
                        m_run++;
                        if (m_run == CC) m_locked = 1'b1;
                    end else begin
                        m_run   = 0;
                        m_phase = -1;
                    end
                end else if (m_win != COM) begin
                    m_data  = m_win;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                e.edge_no = ecount + 1;
                e.valid   = m_valid;
                e.data    = m_data;
                e.active  = m_locked;
                exp_q.push_back(e);
            end
        end
    endtask

    // Drive one bit for the next rising edge, with the reset level wanted then.
    task automatic send_bit(input logic b);
        @(posedge clk_32f);
        #2;
        reset       = rst_level;
        bus.data_in = b;
        if (rst_level) model_bit(b);
        else           model_reset();
        last_bit_edge = ecount + 1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255)); while (v == COM);
        return v;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"},  bus.data_out,  8'h00);
        check({tag, "_valid_out"}, bus.valid_out, 1'b0);
        check({tag, "_byte_strb"}, bus.byte_strb, 1'b0);
        check({tag, "_active"},    bus.active,    1'b0);
    endtask

    // Monitor: output levels every cycle, strobes against the scoreboard.
    initial begin : monitor
        strb_exp_t e;
        forever begin
            @(posedge clk_32f);
            #1;
            check("active_level", bus.active,    m_locked);
            check("valid_level",  bus.valid_out, m_valid);
            check("data_level",   bus.data_out,  m_data);
            if (bus.valid_out) valid_cycles++;
            if (bus.byte_strb) begin
                strb_seen++;
                if (exp_q.size() == 0) begin
                    check("spurious_strb", bus.byte_strb, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("strb_edge",   ecount,        e.edge_no);
                    check("strb_valid",  bus.valid_out, e.valid);
                    check("strb_data",   bus.data_out,  e.data);
                    check("strb_active", bus.active,    e.active);
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_no <= ecount) begin
                check("missing_strb", bus.byte_strb, 1'b1);
                void'(exp_q.pop_front());
            end
            if (bus.active && first_active_edge < 0) begin
                first_active_edge  = ecount;
                strb_before_active = strb_seen;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, edges=%0d", ecount);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lock_edge;
        #1 reset = 1'b0;

        // Reset held for three cycles with a toggling input.
        rst_level = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_outputs_zero("reset_hold");

        // Lock with a 3-bit offset followed by four COMs.
        rst_level          = 1'b1;
        strb_seen          = 0;
        valid_cycles       = 0;
        first_active_edge  = -1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (CC) send_byte(COM);
        lock_edge = last_bit_edge;

        // Data after lock; lock observations are complete by now.
        send_byte(8'hAB);
        check("lock_active_edge", first_active_edge,  lock_edge);
        check("lock_strobes",     strb_before_active, 3);
        check("lock_no_valid",    valid_cycles,       0);
        send_byte(8'hCA);
        send_byte(8'h12);

        // Idle COM after data.
        send_byte(COM);
        send_bit(1'b0);
        check("idle_valid",  bus.valid_out, 1'b0);
        check("idle_data",   bus.data_out,  8'h12);
        check("idle_active", bus.active,    1'b1);

        // False lock: COM, COM, then a non-COM at an aligned position.
        rst_level = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        rst_level = 1'b1;
        strb_seen = 0;
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h55);
        send_bit(1'b0);
        check("falselock_active",  bus.active, 1'b0);
        check("falselock_strobes", strb_seen,  2);
        repeat (CC) send_byte(COM);
        send_bit(1'b1);
        check("relock_active", bus.active, 1'b1);

        // Reset at bit 3 of a data byte while active.
        send_byte(8'h5A);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("pre_reset_valid", bus.valid_out, 1'b1);
        rst_level = 1'b0;
        send_bit(1'b0);
        #1;
        check_outputs_zero("midop_reset");
        send_bit(1'b0);
        rst_level    = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 6; i++) send_byte(rand_data());
        send_bit(1'b0);
        check("post_reset_no_valid",  valid_cycles, 0);
        check("post_reset_no_active", bus.active,   1'b0);

        // Randomized streams: random offset, random COM run, mixed traffic.
        for (int r = 0; r < 8; r++) begin
            rst_level = 1'b0;
            send_bit(1'($urandom_range(0, 1)));
            send_bit(1'($urandom_range(0, 1)));
            rst_level = 1'b1;
            for (int i = 0, n = $urandom_range(0, 7); i < n; i++)
                send_bit(1'($urandom_range(0, 1)));
            for (int i = 0, n = $urandom_range(2, 5); i < n; i++)
                send_byte(COM);
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 3) == 0) send_byte(COM);
                else                           send_byte(rand_data());
            end
        end

        // Let the edge that samples the final bit be observed.
        @(posedge clk_32f);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Serial-to-parallel receiver for the PCI physical-layer link; the inverse of the parallel-to-serial transmitter. It samples a 1-bit MSB-first stream on `clk_32f` and locks byte alignment on a run of COM characters (8'hBC). Once locked, it delivers one 8-bit byte per 8 clock cycles with a valid flag, so data bytes can be separated from idle COM fill. It sits between the serial lane and the byte-wide logic clocked at the 4f rate.

## Interface
- `COMMA`, 8'hBC: alignment/idle character.
- `COMMA_COUNT`, 4: consecutive aligned COMs required to go active (legal range 1..15).
- `clk_32f`  input  1  bit-rate clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `data_in`  input  1  serial bit, MSB of each byte first.
- `data_out`  output  8  last received data byte.
- `valid_out`  output  1  high while `data_out` holds a non-COM byte received in ACTIVE.
- `byte_strb`  output  1  one-cycle pulse at each byte boundary once aligned (ALIGNING or ACTIVE).
- `active`  output  1  high in ACTIVE state.

## Operation
- 8-bit shift register: `sr <= {sr[6:0], data_in}` every cycle. The candidate byte is `{sr[6:0], data_in}`.
- 3-bit `bit_cnt` marks byte boundaries. A boundary is the cycle where `bit_cnt == 7`. The counter wraps from 7 to 0.
- 4-bit `comma_cnt` counts consecutive aligned COMs.
- **UNALIGNED** (reset state):
  - Compare the candidate byte to `COMMA` every cycle.
  - On a match: `bit_cnt <= 0`, `comma_cnt <= 1`. Go to ACTIVE if `COMMA_COUNT == 1`, otherwise to ALIGNING.
  - No strobes are generated in this state.
- **ALIGNING**:
  - At each boundary, pulse `byte_strb`.
  - Candidate == COMMA: increment `comma_cnt`. When the incremented value equals `COMMA_COUNT`, go to ACTIVE.
  - Candidate != COMMA: clear `comma_cnt` and return to UNALIGNED.
  - `valid_out` stays 0 in this state.
- **ACTIVE**:
  - Stays in ACTIVE until reset; there is no loss-of-sync exit.
  - At each boundary, pulse `byte_strb`.
  - Candidate != COMMA: `data_out <= candidate`, `valid_out <= 1`.
  - Candidate == COMMA: `valid_out <= 0`, `data_out` holds its previous value.
- Reset values (applied asynchronously): all outputs 0, `sr = 0`, `bit_cnt = 0`, `comma_cnt = 0`, state UNALIGNED.

## Timing
- Outputs are registered. `data_out`, `valid_out` and `byte_strb` change on the edge that samples the 8th bit of a byte, so they are visible from the following cycle.
- `data_out` and `valid_out` are held stable for exactly 8 cycles, from one boundary to the next.
- `active` rises on the edge that samples the last bit of the `COMMA_COUNT`-th COM.
- Data latency: the last bit of a byte is sampled at edge N; `data_out` is valid after edge N, so the byte is usable at edge N+1.
- Simultaneous events:
  - Reset asserted mid-byte clears outputs immediately. After release, alignment restarts from UNALIGNED, which requires `COMMA_COUNT` new COMs.
  - In UNALIGNED, a COM-like pattern straddling two bytes is accepted as alignment. The following aligned bytes must all be COMs, or the block falls back to UNALIGNED.
- Throughput: one byte per 8 cycles, with no backpressure.

## Structure
- Package `serial_paralelo_pkg`:
  - COM constant 8'hBC.
  - State enum UNALIGNED/ALIGNING/ACTIVE (2-bit encoding).
  - `BITS_PER_BYTE = 8`.
  - The transmitter shares this package for COM.
- One sub-module, `rx_shift_reg`: the shift register plus candidate-byte output.
- Top level holds the FSM, counters and output registers.

## Test plan
- Reset: hold `reset = 0` for 3 cycles while toggling `data_in`. Required: `data_out = 00`, `valid_out = 0`, `byte_strb = 0`, `active = 0` throughout.
- Lock with offset: send bits 1,0,1, then four COMs (8'hBC) MSB first. Required:
  - `active` rises 1 cycle after the 35th bit.
  - `valid_out` never asserts.
  - `byte_strb` pulses 3 times before `active` rises.
- Data: after lock, send AB, CA, 12. Required: `data_out` = AB, CA, 12 in turn, each held 8 cycles with `valid_out = 1` and one `byte_strb` pulse per byte.
- Idle: in ACTIVE, send BC after 12. Required: `valid_out = 0` for 8 cycles, `data_out` stays 12, `active` stays 1.
- Failed alignment: send BC, BC, 55. Required:
  - Returns to UNALIGNED with `active = 0`.
  - A subsequent run of four BCs then locks.
- Reset mid-operation: assert `reset` at bit 3 of a data byte while ACTIVE. Required:
  - All outputs 0 immediately.
  - Data sent after release without COMs produces no `valid_out`.
